// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch FSM states, boot/exception vectors, kseg constants and the bus address map (INST_FETCH_KSEG_MAP_EN)
package cpu_pkg;
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} fetch_state_t;
    localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;
    localparam logic [2:0]  KSEG0        = 3'b100;
    localparam logic [2:0]  KSEG1        = 3'b101;
    function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef INST_FETCH_KSEG_MAP_EN
        return (a[31:29] == KSEG0 || a[31:29] == KSEG1) ? {3'b000, a[28:0]} : a;
`else
        return a;
`endif
    endfunction
endpackage

// File: rtl/fetch_pair_buf.sv
// fetch_pair_buf: tagged one-entry buffer holding an instruction pair plus its fault bit
module fetch_pair_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_wr,
    input  logic [31:0] i_tag,
    input  logic [31:0] i_w0,
    input  logic [31:0] i_w1,
    input  logic        i_err,
    input  logic [31:0] i_pc,
    output logic        o_hit,
    output logic [31:0] o_w0,
    output logic [31:0] o_w1,
    output logic        o_err
);
    logic        r_valid;
    logic [31:0] r_tag;
    // capture a completed pair, or invalidate when a new miss begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            o_w0    <= '0;
            o_w1    <= '0;
            o_err   <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            o_w0    <= i_w0;
            o_w1    <= i_w1;
            o_err   <= i_err;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end
    assign o_hit = r_valid && r_tag == i_pc;
endmodule

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: IF-side responder returning {word@pc, word@pc+4} over an SRAM-like bus (INST_FETCH_KSEG_MAP_EN maps kseg0/1)
module inst_fetch_bridge
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          BUS_AW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_inst_2,
    output logic              delay_hard,
    output logic              IADEE,
    output logic              IADFE,
    output logic              inst_req,
    output logic [BUS_AW-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [31:0]       inst_rdata,
    input  logic              inst_data_ok,
    input  logic              inst_err
);
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end
    fetch_state_t r_state, w_next;
    logic [31:0]  r_fetch_pc, r_w0;
    logic         r_e0;
    logic         w_hit, w_misalign, w_stale, w_clr, w_wr, w_err;
    logic [31:0]  w_w0, w_w1, w_addr;
    assign w_misalign = pc[1:0] != 2'b00;
    assign w_stale    = pc != r_fetch_pc;
    fetch_pair_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_wr  (w_wr),
        .i_tag (r_fetch_pc),
        .i_w0  (r_w0),
        .i_w1  (inst_rdata),
        .i_err (r_e0 | inst_err),
        .i_pc  (pc),
        .o_hit (w_hit),
        .o_w0  (w_w0),
        .o_w1  (w_w1),
        .o_err (w_err)
    );
    assign delay_hard = !reset || (!w_hit && !w_misalign);
    assign IADEE      = reset && w_misalign;
    assign IADFE      = w_hit && w_err;
    assign if_inst    = w_hit ? w_w0 : '0;
    assign if_inst_2  = w_hit ? w_w1 : '0;
    assign w_addr     = (r_state == REQ0) ? bus_addr(r_fetch_pc) :
                        (r_state == REQ1) ? bus_addr(r_fetch_pc + 32'd4) : '0;
    assign inst_addr  = BUS_AW'(w_addr);
    // next state and bus/buffer controls; a pc change only takes effect when data drains
    always_comb begin
        w_next   = r_state;
        inst_req = 1'b0;
        w_clr    = 1'b0;
        w_wr     = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr  = !w_hit && !w_misalign;
                w_next = w_clr ? REQ0 : IDLE;
            end
            REQ0: begin
                inst_req = 1'b1;
                w_next   = inst_addr_ok ? WAIT0 : REQ0;
            end
            WAIT0: w_next = !inst_data_ok ? WAIT0 : w_stale ? IDLE : REQ1;
            REQ1: begin
                inst_req = 1'b1;
                w_next   = inst_addr_ok ? WAIT1 : REQ1;
            end
            WAIT1: begin
                w_wr   = inst_data_ok && !w_stale;
                w_next = inst_data_ok ? IDLE : WAIT1;
            end
            default: w_next = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // latch the fetch address on a miss and the first word when it returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_w0       <= '0;
            r_e0       <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == REQ0) r_fetch_pc <= pc;
            if (r_state == WAIT0 && inst_data_ok) begin
                r_w0 <= inst_rdata;
                r_e0 <= inst_err;
            end
        end
    end
endmodule
